// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RISC-V
// funct3 width/sign codes, and the helpers that decide whether a request is
// legal and how many low address bits must be zero for its access size.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_t;

    // Load codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Low address bits that must be zero for the access size in funct3[1:0].
    function automatic logic [2:0] align_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Doubleword and unsigned-word codes exist only on a 64-bit datapath.
    function automatic logic funct3_legal(input logic [2:0] funct3,
                                          input logic       store,
                                          input logic       xlen64);
        if (store)
            return (funct3[2:1] != 2'b11) && (xlen64 || funct3 != F3_SD);
        else
            return (funct3 != 3'b111) &&
                   (xlen64 || (funct3 != F3_LD && funct3 != F3_LWU));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
//   funct3      : width/sign code of the registered access
//   byte_offset : low address bits (byte position inside the aligned word)
//   store_data  : rs2 value to be written
//   read_data   : aligned word returned by memory
//   byte_enable : size mask shifted to the addressed lanes
//   write_value : store data replicated across every lane of its size
//   load_value  : addressed lane moved to bit 0, sign- or zero-extended
module lsu_lane_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int BYTES = XLEN / 8,
    localparam int OFFS  = $clog2(BYTES)
) (
    input  logic [2:0]       funct3,
    input  logic [OFFS-1:0]  byte_offset,
    input  logic [XLEN-1:0]  store_data,
    input  logic [XLEN-1:0]  read_data,
    output logic [BYTES-1:0] byte_enable,
    output logic [XLEN-1:0]  write_value,
    output logic [XLEN-1:0]  load_value
);

    logic [BYTES-1:0] size_mask;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  value_mask;
    logic             sign_bit;

    assign shifted     = read_data >> {byte_offset, 3'b000};
    assign byte_enable = size_mask << byte_offset;

    always_comb begin
        size_mask   = '0;
        write_value = store_data;
        value_mask  = '1;
        sign_bit    = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                size_mask   = BYTES'(8'h01);
                write_value = {(XLEN/8){store_data[7:0]}};
                value_mask  = XLEN'(8'hFF);
                sign_bit    = shifted[7];
            end
            2'b01: begin
                size_mask   = BYTES'(8'h03);
                write_value = {(XLEN/16){store_data[15:0]}};
                value_mask  = XLEN'(16'hFFFF);
                sign_bit    = shifted[15];
            end
            2'b10: begin
                size_mask   = BYTES'(8'h0F);
                write_value = {(XLEN/32){store_data[31:0]}};
                value_mask  = XLEN'(32'hFFFF_FFFF);
                sign_bit    = shifted[31];
            end
            default: begin
                size_mask   = '1;
                write_value = store_data;
                value_mask  = '1;
                sign_bit    = shifted[XLEN-1];
            end
        endcase
    end

    // funct3[2] marks the unsigned load variants (LBU/LHU/LWU).
    assign load_value = (shifted & value_mask) |
                        ((sign_bit && !funct3[2]) ? ~value_mask : '0);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a CPU request port and a simple
// memory command/response port.
//   clock, reset                     : single clock, synchronous active-high reset
//   request_*                        : CPU request handshake (ready only in IDLE)
//   funct3, rs1_value, immediate,
//   rs2_value                        : access code, base, offset, store data
//   response_valid/value/error       : one-cycle completion pulse with result
//   memory_request_*, memory_write_*,
//   memory_address, memory_byte_enable: memory command, held stable in ISSUE
//   memory_response_valid,
//   memory_read_value                : memory completion (ignored outside WAIT)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                request_valid,
    output logic                request_ready,
    input  logic                request_store,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     rs1_value,
    input  logic [XLEN-1:0]     immediate,
    input  logic [XLEN-1:0]     rs2_value,
    output logic                response_valid,
    output logic [XLEN-1:0]     response_value,
    output logic                response_error,
    output logic                memory_request_valid,
    input  logic                memory_request_ready,
    output logic                memory_write_enable,
    output logic [XLEN-1:0]     memory_address,
    output logic [XLEN-1:0]     memory_write_value,
    output logic [XLEN/8-1:0]   memory_byte_enable,
    input  logic                memory_response_valid,
    input  logic [XLEN-1:0]     memory_read_value
);

    localparam int BYTES = XLEN / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("load_store_unit: XLEN must be 32 or 64");
    end

    lsu_state_t       state_q, state_d;
    logic [XLEN-1:0]  addr_q;
    logic [2:0]       funct3_q;
    logic             store_q;
    logic [XLEN-1:0]  data_q;
    logic [XLEN-1:0]  result_q;
    logic             error_q;
    logic [CNT_W-1:0] count_q;

    logic [XLEN-1:0]  request_address;
    logic             request_bad;
    logic             timeout;
    logic [BYTES-1:0] lane_byte_enable;
    logic [XLEN-1:0]  lane_write_value;
    logic [XLEN-1:0]  lane_load_value;

    // Wraps modulo 2^XLEN by construction of the adder width.
    assign request_address = rs1_value + immediate;
    assign request_bad     = !funct3_legal(funct3, request_store, XLEN == 64) ||
                             (|(request_address[2:0] & align_mask(funct3)));
    // Leaving on count T-1 makes the error pulse land exactly T cycles after WAIT entry.
    assign timeout         = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
        .funct3      (funct3_q),
        .byte_offset (addr_q[OFFS-1:0]),
        .store_data  (data_q),
        .read_data   (memory_read_value),
        .byte_enable (lane_byte_enable),
        .write_value (lane_write_value),
        .load_value  (lane_load_value)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: datapath registers are reset as well, so nothing left over
            // from an abandoned transaction can reach the outputs later.
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            data_q   <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    count_q <= '0;
                    if (request_valid) begin
                        addr_q   <= request_address;
                        funct3_q <= funct3;
                        store_q  <= request_store;
                        data_q   <= rs2_value;
                        result_q <= '0;
                        error_q  <= request_bad;
                    end
                end
                ST_WAIT: begin
                    count_q <= count_q + CNT_W'(1);
                    if (memory_response_valid) begin
                        result_q <= store_q ? '0 : lane_load_value;
                        error_q  <= 1'b0;
                    end else if (timeout) begin
                        result_q <= '0;
                        error_q  <= 1'b1;
                    end
                end
                default: count_q <= '0;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d              = state_q;
        request_ready        = 1'b0;
        response_valid       = 1'b0;
        response_value       = '0;
        response_error       = 1'b0;
        memory_request_valid = 1'b0;
        memory_write_enable  = 1'b0;
        memory_address       = '0;
        memory_write_value   = '0;
        memory_byte_enable   = '0;
        case (state_q)
            ST_IDLE: begin
                request_ready = 1'b1;
                if (request_valid)
                    state_d = request_bad ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                memory_request_valid = 1'b1;
                memory_write_enable  = store_q;
                memory_address       = {addr_q[XLEN-1:OFFS], {OFFS{1'b0}}};
                memory_write_value   = store_q ? lane_write_value : '0;
                memory_byte_enable   = lane_byte_enable;
                if (memory_request_ready)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (memory_response_valid || timeout)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                response_valid = 1'b1;
                response_value = result_q;
                response_error = error_q;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 32-bit instance for the main
// scenarios and a 64-bit instance for doubleword and wide word loads.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;

    // 32-bit instance
    logic        request_valid, request_ready, request_store;
    logic [2:0]  funct3;
    logic [31:0] rs1_value, immediate, rs2_value;
    logic        response_valid, response_error;
    logic [31:0] response_value;
    logic        memory_request_valid, memory_request_ready, memory_write_enable;
    logic [31:0] memory_address, memory_write_value, memory_read_value;
    logic [3:0]  memory_byte_enable;
    logic        memory_response_valid;

    // 64-bit instance
    logic        w_request_valid, w_request_ready, w_request_store;
    logic [2:0]  w_funct3;
    logic [63:0] w_rs1_value, w_immediate, w_rs2_value;
    logic        w_response_valid, w_response_error;
    logic [63:0] w_response_value;
    logic        w_memory_request_valid, w_memory_request_ready, w_memory_write_enable;
    logic [63:0] w_memory_address, w_memory_write_value, w_memory_read_value;
    logic [7:0]  w_memory_byte_enable;
    logic        w_memory_response_valid;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(15)) dut32 (
        .clock                 (clock),
        .reset                 (reset),
        .request_valid         (request_valid),
        .request_ready         (request_ready),
        .request_store         (request_store),
        .funct3                (funct3),
        .rs1_value             (rs1_value),
        .immediate             (immediate),
        .rs2_value             (rs2_value),
        .response_valid        (response_valid),
        .response_value        (response_value),
        .response_error        (response_error),
        .memory_request_valid  (memory_request_valid),
        .memory_request_ready  (memory_request_ready),
        .memory_write_enable   (memory_write_enable),
        .memory_address        (memory_address),
        .memory_write_value    (memory_write_value),
        .memory_byte_enable    (memory_byte_enable),
        .memory_response_valid (memory_response_valid),
        .memory_read_value     (memory_read_value)
    );

    load_store_unit #(.XLEN(64), .TIMEOUT_CYCLES(15)) dut64 (
        .clock                 (clock),
        .reset                 (reset),
        .request_valid         (w_request_valid),
        .request_ready         (w_request_ready),
        .request_store         (w_request_store),
        .funct3                (w_funct3),
        .rs1_value             (w_rs1_value),
        .immediate             (w_immediate),
        .rs2_value             (w_rs2_value),
        .response_valid        (w_response_valid),
        .response_value        (w_response_value),
        .response_error        (w_response_error),
        .memory_request_valid  (w_memory_request_valid),
        .memory_request_ready  (w_memory_request_ready),
        .memory_write_enable   (w_memory_write_enable),
        .memory_address        (w_memory_address),
        .memory_write_value    (w_memory_write_value),
        .memory_byte_enable    (w_memory_byte_enable),
        .memory_response_valid (w_memory_response_valid),
        .memory_read_value     (w_memory_read_value)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one request to the 32-bit unit for exactly one accepting edge.
    task automatic send32(input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] imm, input logic [31:0] data);
        check("accept_ready", request_ready, 1'b1);
        request_valid = 1'b1;
        request_store = st;
        funct3        = f3;
        rs1_value     = base;
        immediate     = imm;
        rs2_value     = data;
        tick();
        request_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        request_valid = 0; request_store = 0; funct3 = 0;
        rs1_value = 0; immediate = 0; rs2_value = 0;
        memory_request_ready = 0; memory_response_valid = 0; memory_read_value = 0;
        w_request_valid = 0; w_request_store = 0; w_funct3 = 0;
        w_rs1_value = 0; w_immediate = 0; w_rs2_value = 0;
        w_memory_request_ready = 0; w_memory_response_valid = 0; w_memory_read_value = 0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready",     request_ready, 1'b1);
        check("rst_resp",      response_valid, 1'b0);
        check("rst_mem_valid", memory_request_valid, 1'b0);
        check("rst_mem_addr",  memory_address, 32'h0);
        check("rst_be",        memory_byte_enable, 4'h0);
        check("rst_ready64",   w_request_ready, 1'b1);

        // LB at 0x103 of 0x80FF_1234, zero-wait memory: N, N+1 ISSUE, N+2 WAIT, N+3 DONE
        memory_request_ready = 1'b1;
        send32(1'b0, 3'b000, 32'h100, 32'h3, 32'h0);
        check("lb_issue_valid", memory_request_valid, 1'b1);
        check("lb_issue_addr",  memory_address, 32'h100);
        check("lb_issue_we",    memory_write_enable, 1'b0);
        check("lb_busy_ready",  request_ready, 1'b0);
        tick();
        check("lb_wait_valid",  memory_request_valid, 1'b0);
        memory_response_valid = 1'b1;
        memory_read_value     = 32'h80FF_1234;
        tick();
        memory_response_valid = 1'b0;
        check("lb_resp_valid",  response_valid, 1'b1);
        check("lb_resp_value",  response_value, 32'hFFFF_FF80);
        check("lb_resp_error",  response_error, 1'b0);
        tick();
        check("lb_after_valid", response_valid, 1'b0);
        check("lb_after_ready", request_ready, 1'b1);

        // SH at 0x202 of 0xBEEF
        send32(1'b1, 3'b001, 32'h200, 32'h2, 32'h0000_BEEF);
        check("sh_addr",  memory_address, 32'h200);
        check("sh_be",    memory_byte_enable, 4'b1100);
        check("sh_wdata", memory_write_value, 32'hBEEF_BEEF);
        check("sh_we",    memory_write_enable, 1'b1);
        tick();
        memory_response_valid = 1'b1;
        tick();
        memory_response_valid = 1'b0;
        check("sh_resp_valid", response_valid, 1'b1);
        check("sh_resp_value", response_value, 32'h0);
        check("sh_resp_error", response_error, 1'b0);
        tick();

        // SB with negative offset: 0x14 + (-2) = 0x12, lane 2
        send32(1'b1, 3'b000, 32'h14, 32'hFFFF_FFFE, 32'h1234_5678);
        check("sb_addr",  memory_address, 32'h10);
        check("sb_be",    memory_byte_enable, 4'b0100);
        check("sb_wdata", memory_write_value, 32'h7878_7878);
        tick();
        memory_response_valid = 1'b1;
        tick();
        memory_response_valid = 1'b0;
        check("sb_resp_valid", response_valid, 1'b1);
        tick();

        // Misaligned LW at 0x102: straight to DONE, no memory command
        send32(1'b0, 3'b010, 32'h100, 32'h2, 32'h0);
        check("mis_resp_valid", response_valid, 1'b1);
        check("mis_resp_error", response_error, 1'b1);
        check("mis_mem_valid",  memory_request_valid, 1'b0);
        tick();
        check("mis_idle_ready", request_ready, 1'b1);
        check("mis_idle_mem",   memory_request_valid, 1'b0);

        // LD is illegal on a 32-bit unit even when aligned
        send32(1'b0, 3'b011, 32'h0, 32'h0, 32'h0);
        check("ill_resp_valid", response_valid, 1'b1);
        check("ill_resp_error", response_error, 1'b1);
        check("ill_mem_valid",  memory_request_valid, 1'b0);
        tick();

        // Timeout: LW at 0xFFFF_FFFC + 8 wraps to 0x4, memory never answers
        send32(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h0);
        check("to_wrap_addr", memory_address, 32'h4);
        tick();  // first WAIT cycle
        for (int i = 1; i < 15; i++) begin
            tick();
            check("to_no_resp", response_valid, 1'b0);
        end
        tick();  // 15 cycles after WAIT entry
        check("to_resp_valid", response_valid, 1'b1);
        check("to_resp_error", response_error, 1'b1);
        check("to_resp_value", response_value, 32'h0);
        tick();
        check("to_idle_ready", request_ready, 1'b1);

        // Backpressure with a stale response during ISSUE, then LHU at 0x8002
        memory_request_ready  = 1'b0;
        memory_response_valid = 1'b1;
        memory_read_value     = 32'hDEAD_BEEF;
        send32(1'b0, 3'b101, 32'h8000, 32'h2, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", memory_request_valid, 1'b1);
            check("bp_addr",  memory_address, 32'h8000);
            check("bp_we",    memory_write_enable, 1'b0);
            check("bp_be",    memory_byte_enable, 4'b1100);
            tick();
        end
        check("bp_still_issue", memory_request_valid, 1'b1);
        memory_response_valid = 1'b0;
        memory_request_ready  = 1'b1;
        tick();
        check("bp_wait_valid", memory_request_valid, 1'b0);
        memory_response_valid = 1'b1;
        memory_read_value     = 32'h8001_0000;
        tick();
        memory_response_valid = 1'b0;
        check("lhu_resp_valid", response_valid, 1'b1);
        check("lhu_resp_value", response_value, 32'h0000_8001);
        tick();

        // Reset while in WAIT, then a stale memory response
        send32(1'b0, 3'b010, 32'h10, 32'h0, 32'h0);
        tick();  // WAIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready",  request_ready, 1'b1);
        check("mid_rst_mem",    memory_request_valid, 1'b0);
        check("mid_rst_resp",   response_valid, 1'b0);
        memory_response_valid = 1'b1;
        memory_read_value     = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stale_no_resp", response_valid, 1'b0);
            check("stale_ready",   request_ready, 1'b1);
        end
        memory_response_valid = 1'b0;

        // 64-bit: LD at 0x8 returns the whole word
        w_memory_request_ready = 1'b1;
        w_request_valid = 1'b1;
        w_request_store = 1'b0;
        w_funct3        = 3'b011;
        w_rs1_value     = 64'h8;
        w_immediate     = 64'h0;
        tick();
        w_request_valid = 1'b0;
        check("ld64_addr", w_memory_address, 64'h8);
        check("ld64_be",   w_memory_byte_enable, 8'hFF);
        tick();
        w_memory_response_valid = 1'b1;
        w_memory_read_value     = 64'h8123_4567_89AB_CDEF;
        tick();
        w_memory_response_valid = 1'b0;
        check("ld64_resp_valid", w_response_valid, 1'b1);
        check("ld64_resp_value", w_response_value, 64'h8123_4567_89AB_CDEF);
        check("ld64_resp_error", w_response_error, 1'b0);
        tick();

        // 64-bit: LW at 0xC sign-extends the upper word
        w_request_valid = 1'b1;
        w_funct3        = 3'b010;
        w_rs1_value     = 64'h4;
        w_immediate     = 64'h8;
        tick();
        w_request_valid = 1'b0;
        check("lw64_addr", w_memory_address, 64'h8);
        check("lw64_be",   w_memory_byte_enable, 8'hF0);
        tick();
        w_memory_response_valid = 1'b1;
        w_memory_read_value     = 64'h8765_4321_0000_0000;
        tick();
        w_memory_response_valid = 1'b0;
        check("lw64_resp_value", w_response_value, 64'hFFFF_FFFF_8765_4321);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
